cla_serial_adder16: RTL and testbench

CLA_SERIAL_ADDER16 -- requirements
Module: cla_serial_adder16

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_serial_adder16_if.sv | 24 ++
 rtl/cla.sv | 26 ++
 rtl/cla_serial_adder16.sv | 126 ++++++++++++
 tb/tb_cla_serial_adder16.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nibble index width; a single-nibble adder still needs a one-bit index.
    function automatic int idx_width(input int nibs);
        return (nibs > 1) ? $clog2(nibs) : 1;
    endfunction

endpackage

// File: rtl/cla_serial_adder16_if.sv
// Operand/result handshake bundle between a producer/consumer and the serial adder.
interface cla_serial_adder16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/cla.sv
// 4-bit carry-lookahead adder: all carries formed directly from generate/propagate terms.
module cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:1] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ {c[3:1], cin};
    end

endmodule

// File: rtl/cla_serial_adder16.sv
// Nibble-serial adder: one shared 4-bit CLA walks the operands LSB-first, one nibble per cycle,
// with a carry register linking the steps.
module cla_serial_adder16
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cla_serial_adder16_if.slave   bus
);

    localparam int NIBS  = WIDTH / NIB_W;
    localparam int IDX_W = idx_width(NIBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_cout_q, out_cout_d;

    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*NIB_W +: NIB_W];
                nib_b = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    cla u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Output registers load only when the result completes, so sum/cout
    // keep the previous result while the working sum register is rebuilt.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        carry_d    = carry_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*NIB_W +: NIB_W] = nib_sum;
                    end
                end
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    out_sum_d  = sum_d;
                    out_cout_d = nib_cout;
                    state_d    = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sum_q      <= sum_d;
            carry_q    <= carry_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = out_sum_q;
    assign bus.cout      = out_cout_q;

endmodule

// File: tb/tb_cla_serial_adder16.sv
// Scoreboard bench for the nibble-serial CLA adder: directed vectors plus random back-to-back traffic.
module tb_cla_serial_adder16;

    localparam int WIDTH = 16;
    localparam int NIBS  = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
    } result_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_accept = -1;
    bit   check_rate = 1'b0;
    result_t expq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cla_serial_adder16_if #(.WIDTH(WIDTH)) bus ();

    cla_serial_adder16 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every presented-and-accepted result is matched against the oldest expectation.
    always @(negedge clk) begin
        result_t r;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
                r = expq.pop_front();
                checkOutput("sum", 32'(bus.sum), 32'(r.sum));
                checkOutput("cout", 32'(bus.cout), 32'(r.cout));
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                                 input logic [WIDTH-1:0] want_sum, input logic want_cout, input bit hold);
        int n = 0;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        expq.push_back({want_sum, want_cout});
        @(posedge clk);
        #1;
        if (check_rate && last_accept >= 0)
            checkOutput("accept_interval", 32'(cyc - last_accept), 32'(NIBS + 2));
        last_accept = cyc;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic waitOutValid(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
        end
        if (bus.out_valid !== 1'b1) checkOutput("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) checkOutput("drain_timeout", 32'(expq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int               lat;
        int               rel_cyc;
        logic [WIDTH-1:0] ra, rb, rs;
        logic             rc, rco;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_sum", 32'(bus.sum), 32'd0);
        checkOutput("reset_cout", 32'(bus.cout), 32'd0);
        rst_n   = 1'b1;
        rel_cyc = cyc;

        // Small add: first accept right after reset release, then latency.
        applyStimulus(16'h0001, 16'h0006, 1'b0, 16'h0007, 1'b0, 1'b0);
        checkOutput("first_accept_delay", 32'(last_accept - rel_cyc), 32'd1);
        #3;
        checkOutput("run_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("run_out_valid", 32'(bus.out_valid), 32'd0);
        waitOutValid(lat);
        checkOutput("latency", 32'(lat), 32'(NIBS));

        // Full ripple; outputs must keep the previous result during RUN.
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("run_hold_sum", 32'(bus.sum), 32'h0007);
        checkOutput("run_hold_cout", 32'(bus.cout), 32'd0);

        applyStimulus(16'h0009, 16'h0003, 1'b1, 16'h000D, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        waitDrain();

        // Consumer stall in DONE with new operands pulsed on the input side.
        bus.out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        waitOutValid(lat);
        repeat (5) begin
            @(posedge clk);
            #1;
            bus.in_valid = ~bus.in_valid;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.cin      = 1'($urandom_range(0, 1));
            @(negedge clk);
            checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall_sum", 32'(bus.sum), 32'h3333);
            checkOutput("stall_cout", 32'(bus.cout), 32'd0);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_stall_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("post_stall_out_valid", 32'(bus.out_valid), 32'd0);
        waitDrain();

        // Abort mid-run at idx=2; the aborted result must never appear.
        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        expq.delete();
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_sum", 32'(bus.sum), 32'd0);
        checkOutput("abort_cout", 32'(bus.cout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        waitDrain();

        // Back-to-back random traffic with in_valid and out_ready held high.
        check_rate  = 1'b1;
        last_accept = -1;
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            {rco, rs} = 17'(ra) + 17'(rb) + 17'(rc);
            applyStimulus(ra, rb, rc, rs, rco, 1'b1);
        end
        bus.in_valid = 1'b0;
        check_rate   = 1'b0;
        waitDrain();

        checkOutput("queue_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
